// File: rtl/apb_slave_regbank.sv
// APB4 completer register bank: ID register, saturating error counter and byte-strobed storage,
// with a per-transfer wait-state count sampled during SETUP.
module apb_slave_regbank #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE = 'hA5B0_0001
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [3:0]              wait_cfg,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);

   localparam int unsigned IdxW  = $clog2(NUM_REGS);
   localparam int unsigned StrbW = DATA_WIDTH / 8;

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [StrbW-1:0]        strb_q;
   logic [DATA_WIDTH-1:0]   err_cnt_q;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

   logic                    setup;
   logic                    last;
   logic                    done;
   logic [IdxW-1:0]         idx;
   logic                    misaligned;
   logic                    out_of_range;
   logic                    ro_write;
   logic                    err;
   logic [DATA_WIDTH-1:0]   rd_val;

   // psel with penable in IDLE is a protocol violation and is not treated as SETUP
   assign setup = (state_q == StIdle) && psel && !penable;

   // All decode works on the SETUP-captured address so mid-transfer bus changes are harmless
   assign idx          = addr_q[IdxW+1:2];
   assign misaligned   = addr_q[1:0] != 2'b00;
   assign out_of_range = (addr_q >> (IdxW + 2)) != '0;
   assign ro_write     = write_q && (idx[IdxW-1:1] == '0);
   assign err          = misaligned || out_of_range || ro_write;

   assign last = (state_q == StAccess) && psel && (cnt_q == 4'd0);
   assign done = last && penable;

   always_comb begin
      rd_val = regs_q[idx];
      if (idx == IdxW'(0)) begin
         rd_val = ID_VALUE;
      end else if (idx == IdxW'(1)) begin
         rd_val = err_cnt_q;
      end
   end

   always_comb begin
      pready  = last;
      pslverr = last && err;
      prdata  = '0;
      if (last && !write_q && !err) begin
         prdata = rd_val;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (setup) begin
               state_d = StAccess;
               cnt_d   = wait_cfg;
            end
         end
         StAccess: begin
            if (!psel) begin
               state_d = StIdle;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (penable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_cnt_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
         end
         if (done && err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + DATA_WIDTH'(1);
         end
         if (done && !err && write_q) begin
            for (int b = 0; b < StrbW; b++) begin
               if (strb_q[b]) begin
                  regs_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: the driver pushes model-predicted responses, a
// negedge monitor pops them whenever pready is seen and checks data, error and completion cycle.
module tb_apb_slave_regbank;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [3:0]  wait_cfg = '0;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   apb_slave_regbank #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .NUM_REGS  (16),
      .ID_VALUE  (ID)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .wait_cfg(wait_cfg),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   always #5 pclk = ~pclk;

   longint cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      longint      at;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem [16];
   logic [31:0] errcnt;

   function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   // Reference model: register map rules applied directly to an array
   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      errcnt = '0;
   endtask

   task automatic model_xfer(input bit wr, input int a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output bit err);
      int idx;
      idx = a / 4;
      err = (a % 4 != 0) || (a >= 64) || (wr && idx < 2);
      rd  = '0;
      if (err) begin
         if (errcnt != 32'hFFFF_FFFF) errcnt = errcnt + 1;
      end else if (wr) begin
         for (int b = 0; b < 4; b++) if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
         rd = (idx == 0) ? ID : (idx == 1) ? errcnt : mem[idx];
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that ends the transfer
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int w, input int abort_at);
      exp_t        e;
      bit          err;
      logic [31:0] rd;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      wait_cfg = 4'(w);
      if (abort_at < 0) begin
         model_xfer(wr, int'(a), d, s, rd, err);
         e.rdata = rd; e.err = err; e.at = cyc + 1 + w;
         sb.push_back(e);
      end
      @(posedge pclk); #1;
      penable = 1'b1;
      wait_cfg = 4'($urandom);
      pwdata = $urandom;
      pstrb = 4'($urandom);
      paddr = 8'($urandom);
      if (abort_at >= 0) begin
         repeat (abort_at) @(posedge pclk);
         #1;
         psel = 1'b0; penable = 1'b0;
         @(posedge pclk); #1;
      end else begin
         repeat (w + 1) @(posedge pclk);
         #1;
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   always @(negedge pclk) begin
      if (!preset) begin
         if (pready) begin
            if (sb.size() == 0) begin
               check("unexpected_pready", 1, 0);
            end else begin
               cur = sb.pop_front();
               check("pready_cycle", cyc, cur.at);
               check("pslverr", pslverr, cur.err);
               check("prdata", prdata, cur.rdata);
            end
         end else begin
            check("idle_outputs", {prdata, 31'd0, pslverr}, 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int          w, ab;
      logic [7:0]  a;
      model_reset();
      idle(2);
      preset = 1'b0;

      // ID and empty storage
      xfer(0, 8'h00, 0, 4'h0, 0, -1);
      xfer(0, 8'h08, 0, 4'h0, 0, -1);
      // Strobed write with wait states, then readback
      xfer(1, 8'h08, 32'hDEAD_BEEF, 4'b0101, 3, -1);
      xfer(0, 8'h08, 0, 4'h0, 0, -1);
      // Error cases, ID unchanged, error count of three
      xfer(1, 8'h00, 32'h1111_1111, 4'hF, 0, -1);
      xfer(0, 8'h41, 0, 4'h0, 1, -1);
      xfer(0, 8'h40, 0, 4'h0, 0, -1);
      xfer(0, 8'h00, 0, 4'h0, 0, -1);
      xfer(0, 8'h04, 0, 4'h0, 0, -1);
      // Back-to-back write then read
      xfer(1, 8'h0C, 32'h1234_5678, 4'hF, 0, -1);
      xfer(0, 8'h0C, 0, 4'h0, 0, -1);
      // Abort leaves the register alone
      xfer(1, 8'h0C, 32'hFFFF_FFFF, 4'hF, 5, 3);
      xfer(0, 8'h0C, 0, 4'h0, 0, -1);
      // Zero-strobe write is a legal no-op
      xfer(1, 8'h0C, 32'h0BAD_0BAD, 4'h0, 1, -1);
      xfer(0, 8'h0C, 0, 4'h0, 0, -1);
      // psel with penable in IDLE is ignored
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pstrb = 4'hF;
      idle(3);
      psel = 1'b0; penable = 1'b0;
      xfer(0, 8'h0C, 0, 4'h0, 0, -1);

      // Reset in the middle of a write access
      xfer(1, 8'h10, 32'hCAFE_F00D, 4'hF, 0, -1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h5555_AAAA;
      pstrb = 4'hF; wait_cfg = 4'd3;
      idle(1);
      penable = 1'b1;
      idle(1);
      preset = 1'b1; psel = 1'b0; penable = 1'b0;
      idle(1);
      preset = 1'b0;
      model_reset();
      check("reset_outputs", {prdata, 30'd0, pready, pslverr}, 64'd0);
      xfer(0, 8'h10, 0, 4'h0, 0, -1);
      xfer(0, 8'h04, 0, 4'h0, 0, -1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
         else a = 8'(4 * $urandom_range(0, 15));
         w  = $urandom_range(0, 3);
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w) : -1;
         xfer(1'($urandom), a, $urandom, 4'($urandom), w, ab);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      for (int i = 0; i < 16; i++) xfer(0, 8'(4 * i), 0, 4'h0, 0, -1);

      idle(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
